fifo_arbiter: RTL and testbench
===============================

# fifo_arbiter

Round-robin arbiter and router that sits directly downstream of the transmit-layer FIFOs. It pops words from four input FIFOs, fairly and one per cycle at most. It steers each word into one of four output FIFOs selected by the word's two MSBs. It applies backpressure from the output FIFOs' almost-full flags so that no output FIFO overflows.

## Interface
Parameters:
- data_width, 6, word width; bits [data_width-1:data_width-2] are the destination field.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- empty_in  in  4  empty flags of input FIFOs 0..3.
- data_in  in  4*data_width  packed input FIFO data_out buses; FIFO i occupies [i*data_width +: data_width].
- almost_full_out  in  4  almost-full flags of output FIFOs 0..3.
- pop  out  4  one-hot rd_enable to input FIFOs.
- push  out  4  one-hot wr_enable to output FIFOs.
- data_out  out  data_width  word written to output FIFOs.
- idle  out  1  high when no pop or word is in flight and all inputs are empty.
- word_count  out  8  count of words pushed, wraps modulo 256.

## Operation
- FSM states:
  - INIT: entered on reset; lasts one cycle after reset release; no pops.
  - IDLE: all inputs empty and pipeline empty.
  - ACTIVE: otherwise.
- FSM transitions: INIT→IDLE; IDLE→ACTIVE when any empty_in bit is 0; ACTIVE→IDLE when all empty_in bits are 1 and no stage is valid.
- Pop eligibility in a cycle requires all of:
  - the state is not INIT;
  - almost_full_out == 4'b0000 (conservative, because the destination is unknown before read);
  - at least one empty_in bit is 0.
- Grant: the first non-empty input searching from rr_ptr upward, modulo 4.
  - On a grant, rr_ptr ← grant+1 mod 4.
  - With no grant, rr_ptr holds.
- pop is registered, one-hot, and at most one bit is set. Back-to-back pops to the same or different inputs are allowed.
- The input FIFO presents the word on its data_in slice in the cycle after pop is high. The arbiter captures the slice of the popped index.
- Routing: dest = word[data_width-1:data_width-2].
  - The arbiter registers push[dest]=1 and data_out=word.
  - The full word, including the destination bits, is forwarded unchanged.
- word_count increments by 1 on every cycle with push != 0 and wraps from 255 to 0.
- idle = (state==IDLE). It is registered.
- Output FIFOs must assert almost_full with ≥2 free slots, which covers the 2 words that can be in flight.

## Timing
- Reset values, asynchronous on reset=0:
  - pop=0, push=0, data_out=0, word_count=0, idle=1;
  - rr_ptr=0, pipeline valids=0, state=INIT.
- Latency: pop[i] high in cycle N; word valid on data_in in N+1; push[dest] and data_out valid in N+2. The output FIFO writes at the end of N+2.
- Throughput: 1 word/cycle sustained while inputs are non-empty and there is no backpressure.
- Backpressure response:
  - almost_full_out rising in cycle N forces pop=0 from cycle N+1 onward.
  - Words already popped (at most 2) still complete their pushes.
  - Pops resume in the cycle after almost_full_out returns to 0.
- An empty_in bit sampled 0 is trusted. The arbiter never pops an input whose empty_in bit was 1 in the granting cycle.
- Reset mid-operation: in-flight words are discarded, and push and pop drop immediately. The FSM restarts in INIT, with the first pop possible 2 cycles after reset release.
- Simultaneous grant and backpressure: backpressure wins, so there is no pop and rr_ptr holds.

## Test plan
- Reset, then hold all empty_in high. Required: pop=0, push=0, data_out=0, word_count=0, idle=1 throughout, and no pop in the first cycle after release.
- FIFO 1 holds one word 6'b10_0101. Required: pop=4'b0010 in cycle N, push=4'b0100 with data_out=6'h25 in N+2, word_count=1, idle returns to 1.
- All four FIFOs hold 2 words each, with no backpressure. Required: pops 0,1,2,3,0,1,2,3 on 8 consecutive cycles, 8 pushes back-to-back, word_count=8.
- Continuous stream, then almost_full_out=4'b1000 asserted for 5 cycles. Required: pop stops by the next cycle, at most 2 trailing pushes, no pushes after that, resumes 1 cycle after deassert, no word lost or duplicated.
- Assert reset while words are in flight. Required: pop and push go to 0 immediately, word_count=0, rr_ptr restarts at input 0 after INIT.
- Push 256 words. Required: word_count wraps to 0 on the 256th push; all destination fields route to the matching push bit.

Source files
------------

// File: rtl/fifo_arbiter_if.sv
// Signal bundle between the arbiter, its four input FIFOs and its four output FIFOs.
// master is the arbiter side; slave is the FIFO/environment side.
interface fifo_arbiter_if #(
  parameter int data_width = 6
);
  logic [3:0]              empty_in;
  logic [4*data_width-1:0] data_in;
  logic [3:0]              almost_full_out;
  logic [3:0]              pop;
  logic [3:0]              push;
  logic [data_width-1:0]   data_out;
  logic                    idle;
  logic [7:0]              word_count;

  modport master (
    input  empty_in, data_in, almost_full_out,
    output pop, push, data_out, idle, word_count
  );

  modport slave (
    output empty_in, data_in, almost_full_out,
    input  pop, push, data_out, idle, word_count
  );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin pop arbiter over four input FIFOs, routing each word to one of four
// output FIFOs by its two MSBs, with conservative almost-full backpressure.
module fifo_arbiter #(
  parameter int data_width = 6
) (
  input  logic           clk,
  input  logic           reset,
  fifo_arbiter_if.master bus
);

  typedef enum logic [1:0] {INIT, IDLE, ACTIVE} state_t;

  state_t                state;
  logic [1:0]            rr_ptr;
  logic [1:0]            grant_idx;
  logic                  grant_valid;
  logic                  pop_eligible;
  logic                  pop_valid;
  logic [1:0]            pop_idx;
  logic                  s1_valid;
  logic [1:0]            s1_idx;
  logic [data_width-1:0] cap_word;
  logic [1:0]            dest;

  assign pop_valid = |bus.pop;

  // Any almost-full blocks every pop: the destination is unknown until the word is read.
  assign pop_eligible = (state != INIT) && (bus.almost_full_out == 4'b0000) && !(&bus.empty_in);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      if (pop_eligible && !grant_valid && !bus.empty_in[rr_ptr + 2'(k)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_ptr + 2'(k);
      end
    end
  end

  always_comb begin
    cap_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (s1_idx == 2'(i)) begin
        cap_word = bus.data_in[i*data_width +: data_width];
      end
    end
  end

  assign dest = cap_word[data_width-1 -: 2];

  // idle is registered alongside the state so it always equals (state == IDLE).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      bus.idle <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          state    <= IDLE;
          bus.idle <= 1'b1;
        end
        IDLE: begin
          if (!(&bus.empty_in)) begin
            state    <= ACTIVE;
            bus.idle <= 1'b0;
          end
        end
        ACTIVE: begin
          if ((&bus.empty_in) && !pop_valid && !s1_valid) begin
            state    <= IDLE;
            bus.idle <= 1'b1;
          end
        end
        default: begin
          state    <= INIT;
          bus.idle <= 1'b1;
        end
      endcase
    end
  end

  // Pipeline: pop in N, word on data_in in N+1 (stage s1), push and data_out in N+2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.pop        <= 4'b0000;
      bus.push       <= 4'b0000;
      bus.data_out   <= '0;
      bus.word_count <= 8'd0;
      rr_ptr         <= 2'd0;
      pop_idx        <= 2'd0;
      s1_valid       <= 1'b0;
      s1_idx         <= 2'd0;
    end else begin
      bus.pop <= grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
      if (grant_valid) begin
        pop_idx <= grant_idx;
        rr_ptr  <= grant_idx + 2'd1;
      end
      s1_valid <= pop_valid;
      s1_idx   <= pop_idx;
      if (s1_valid) begin
        bus.push     <= 4'b0001 << dest;
        bus.data_out <= cap_word;
      end else begin
        bus.push <= 4'b0000;
      end
      if (|bus.push) begin
        bus.word_count <= bus.word_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: behavioural input FIFOs, directed loads with hand-computed
// expected pop/push order, and a negedge monitor that scores every pop and push.
module tb_fifo_arbiter;

  localparam int DW = 6;
  typedef logic [DW-1:0] word_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] af_drv = 4'b0000;
  logic       flush_req = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int push_seen   = 0;

  word_t      exp_word_q[$];
  logic [3:0] exp_pop_q[$];
  int         pop_cycles[$];
  int         push_cycles[$];

  word_t      in_q[4][$];
  int         cnt[4];
  word_t      data_reg[4];
  logic [7:0] load_q[$];

  always #5 clk = ~clk;

  fifo_arbiter_if #(.data_width(DW)) bus ();

  fifo_arbiter #(.data_width(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Empty is pop-aware: a word already claimed by a pending pop no longer counts.
  for (genvar g = 0; g < 4; g++) begin : g_fifo
    assign bus.empty_in[g]           = (cnt[g] - (bus.pop[g] ? 1 : 0)) <= 0;
    assign bus.data_in[g*DW +: DW]   = data_reg[g];
  end
  assign bus.almost_full_out = af_drv;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin : input_fifos
    int         n[4];
    word_t      tmp;
    logic [7:0] lw;
    for (int i = 0; i < 4; i++) n[i] = cnt[i];
    if (flush_req) begin
      for (int i = 0; i < 4; i++) begin
        in_q[i].delete();
        n[i] = 0;
      end
      flush_req = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.pop[i] === 1'b1) begin
        vectors++;
        if (in_q[i].size() > 0) begin
          tmp = in_q[i].pop_front();
          data_reg[i] <= tmp;
          n[i]--;
        end else begin
          miscompares++;
          $display("[TB] FAIL underflow: pop of empty input %0d, got pop=%b, required no pop", i, bus.pop);
        end
      end
    end
    while (load_q.size() > 0) begin
      lw = load_q.pop_front();
      in_q[lw[7:6]].push_back(lw[5:0]);
      n[lw[7:6]]++;
    end
    for (int i = 0; i < 4; i++) cnt[i] <= n[i];
  end

  always @(negedge clk) begin : monitor
    logic [3:0] ep;
    word_t      w;
    if (reset === 1'b1) begin
      if (bus.pop !== 4'b0000) begin
        vectors++;
        pop_cycles.push_back(cycle);
        if (exp_pop_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL pop_unexpected: got %b, required 0000", bus.pop);
        end else begin
          ep = exp_pop_q.pop_front();
          if (bus.pop !== ep) begin
            miscompares++;
            $display("[TB] FAIL pop_order: got %b, required %b", bus.pop, ep);
          end
        end
      end
      if (bus.push !== 4'b0000) begin
        vectors++;
        push_cycles.push_back(cycle);
        if (exp_word_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL push_unexpected: got push=%b data=0x%0h, required no push", bus.push, bus.data_out);
        end else begin
          w  = exp_word_q.pop_front();
          ep = 4'b0001 << w[DW-1 -: 2];
          if (bus.push !== ep || bus.data_out !== w) begin
            miscompares++;
            $display("[TB] FAIL push_route: got push=%b data=0x%0h, required push=%b data=0x%0h",
                     bus.push, bus.data_out, ep, w);
          end
        end
        vectors++;
        if (bus.word_count !== 8'(push_seen)) begin
          miscompares++;
          $display("[TB] FAIL word_count_running: got %0d, required %0d", bus.word_count, 8'(push_seen));
        end
        push_seen++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int fifo_idx, input word_t w);
    load_q.push_back({2'(fifo_idx), w});
    exp_pop_q.push_back(4'b0001 << fifo_idx);
    exp_word_q.push_back(w);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_pop", bus.pop, 4'b0000);
    checkOutput("rst_push", bus.push, 4'b0000);
    checkOutput("rst_word_count", bus.word_count, 8'd0);
    checkOutput("rst_data_out", bus.data_out, 6'd0);
    checkOutput("rst_idle", bus.idle, 1'b1);
    exp_word_q.delete();
    exp_pop_q.delete();
    pop_cycles.delete();
    push_cycles.delete();
    push_seen = 0;
    flush_req = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_for_pop(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.pop === 4'b0000 && n < budget);
    vectors++;
    if (bus.pop === 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL pop_timeout: got no pop in %0d cycles, required a pop", budget);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(exp_word_q.size() == 0 && bus.idle === 1'b1 && bus.pop === 4'b0000) && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d words outstanding, required 0", exp_word_q.size());
    end
    checkOutput("pending_pops", exp_pop_q.size(), 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got no finish by 100us, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    word_t wl[8];
    word_t w;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, then release with every input empty.
    checkOutput("t1_rst_pop", bus.pop, 4'b0000);
    checkOutput("t1_rst_push", bus.push, 4'b0000);
    checkOutput("t1_rst_data_out", bus.data_out, 6'd0);
    checkOutput("t1_rst_word_count", bus.word_count, 8'd0);
    checkOutput("t1_rst_idle", bus.idle, 1'b1);
    release_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("t1_pop", bus.pop, 4'b0000);
      checkOutput("t1_push", bus.push, 4'b0000);
      checkOutput("t1_word_count", bus.word_count, 8'd0);
      checkOutput("t1_idle", bus.idle, 1'b1);
    end

    // Single word 10_0101 in FIFO 1: pop 0010, push 0100 two cycles later.
    applyStimulus(1, 6'b10_0101);
    wait_drain(20);
    checkOutput("t2_npop", pop_cycles.size(), 1);
    checkOutput("t2_npush", push_cycles.size(), 1);
    if (pop_cycles.size() == 1 && push_cycles.size() == 1)
      checkOutput("t2_latency", push_cycles[0] - pop_cycles[0], 2);
    checkOutput("t2_word_count", bus.word_count, 8'd1);
    checkOutput("t2_idle", bus.idle, 1'b1);

    // Two words in every FIFO: pops 0,1,2,3,0,1,2,3 back-to-back.
    assert_reset();
    release_reset();
    wl = '{6'h05, 6'h16, 6'h27, 6'h38, 6'h09, 6'h1A, 6'h2B, 6'h3C};
    for (int i = 0; i < 8; i++) applyStimulus(i % 4, wl[i]);
    wait_drain(40);
    checkOutput("t3_word_count", bus.word_count, 8'd8);
    checkOutput("t3_npop", pop_cycles.size(), 8);
    checkOutput("t3_npush", push_cycles.size(), 8);
    if (pop_cycles.size() == 8) checkOutput("t3_pop_span", pop_cycles[7] - pop_cycles[0], 7);
    if (push_cycles.size() == 8) checkOutput("t3_push_span", push_cycles[7] - push_cycles[0], 7);

    // Stream with almost_full_out=1000 held for 5 cycles.
    assert_reset();
    release_reset();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++) begin
        w = word_t'({2'(3 - i), 4'(r * 4 + i)});
        applyStimulus(i, w);
      end
    wait_for_pop(20);
    repeat (2) @(negedge clk);
    af_drv = 4'b1000;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      checkOutput("t4_pop_blocked", bus.pop, 4'b0000);
      if (j >= 3) checkOutput("t4_push_drained", bus.push, 4'b0000);
      if (j == 5) af_drv = 4'b0000;
    end
    @(negedge clk);
    checkOutput("t4_resume", 32'(bus.pop != 4'b0000), 1);
    wait_drain(60);
    checkOutput("t4_word_count", bus.word_count, 8'd16);
    checkOutput("t4_npush", push_cycles.size(), 16);

    // Reset with words in flight; arbitration restarts at input 0.
    assert_reset();
    release_reset();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++) begin
        w = word_t'({2'(i), 4'(r)});
        applyStimulus(i, w);
      end
    wait_for_pop(20);
    repeat (2) @(negedge clk);
    assert_reset();
    for (int i = 0; i < 4; i++) begin
      w = word_t'({2'(3 - i), 4'(4'hA + i)});
      applyStimulus(i, w);
    end
    release_reset();
    @(negedge clk);
    checkOutput("t5_init_no_pop", bus.pop, 4'b0000);
    @(negedge clk);
    checkOutput("t5_first_pop", bus.pop, 4'b0001);
    wait_drain(40);
    checkOutput("t5_word_count", bus.word_count, 8'd4);

    // 256 words across all destinations: word_count wraps to 0.
    assert_reset();
    release_reset();
    for (int r = 0; r < 64; r++)
      for (int i = 0; i < 4; i++) begin
        w = word_t'({2'((r + i) % 4), 4'(r % 16)});
        applyStimulus(i, w);
      end
    wait_drain(400);
    checkOutput("t6_npush", push_cycles.size(), 256);
    checkOutput("t6_word_count_wrap", bus.word_count, 8'd0);
    checkOutput("t6_idle", bus.idle, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
